exe_stage: RTL

Execute stage of the 8-bit pipelined core, fed by the ID/EXE pipeline register and feeding the data-memory stage. It resolves operands via forwarding from the two downstream stages and performs the ALU operation. It holds the architectural carry (C) and zero (Z) flags and registers its results into an integrated EXE/MEM pipeline register.

---
 rtl/exe_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, 8-bit ALU with C/Z flags, and the EXE/MEM pipeline register.
// The flag registers and the EXE/MEM fields clear asynchronously on rst.
module exe_stage #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               regWr_IN,
  input  logic               memRd_IN,
  input  logic               memWr_IN,
  input  logic               cWr_IN,
  input  logic               zWr_IN,
  input  logic [3:0]         aluOp_IN,
  input  logic [RADDR_W-1:0] rd_IN,
  input  logic [RADDR_W-1:0] rs_IN,
  input  logic [RADDR_W-1:0] rt_IN,
  input  logic [DATA_W-1:0]  immConst_IN,
  input  logic [DATA_W-1:0]  regData1_IN,
  input  logic [DATA_W-1:0]  regData2_IN,
  input  logic               squash,
  input  logic               wbRegWr,
  input  logic [RADDR_W-1:0] wbRd,
  input  logic [DATA_W-1:0]  wbData,
  output logic               regWr_OUT,
  output logic               memRd_OUT,
  output logic               memWr_OUT,
  output logic [RADDR_W-1:0] rd_OUT,
  output logic [DATA_W-1:0]  aluResult_OUT,
  output logic [DATA_W-1:0]  storeData_OUT,
  output logic               cFlag,
  output logic               zFlag
);

  logic               reg_wr_q, mem_rd_q, mem_wr_q;
  logic [RADDR_W-1:0] rd_q;
  logic [DATA_W-1:0]  alu_q, store_q;
  logic               c_q, z_q;

  logic [DATA_W-1:0]  fwd_a, fwd_b, op_b;
  logic [DATA_W:0]    a9, b9, res9;
  logic               c_new, z_new;

  // A load sitting in MEM has no data yet, so it is never a forwarding source.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [RADDR_W-1:0] src,
    input logic [DATA_W-1:0]  rf_val,
    input logic               mem_wr,
    input logic               mem_rd,
    input logic [RADDR_W-1:0] mem_rd_addr,
    input logic [DATA_W-1:0]  mem_val,
    input logic               wb_wr,
    input logic [RADDR_W-1:0] wb_rd_addr,
    input logic [DATA_W-1:0]  wb_val
  );
    if (src == RADDR_W'(0))
      return DATA_W'(0);
    else if (mem_wr && !mem_rd && mem_rd_addr == src)
      return mem_val;
    else if (wb_wr && wb_rd_addr == src)
      return wb_val;
    else
      return rf_val;
  endfunction

  always_comb begin
    fwd_a = fwd_sel(rs_IN, regData1_IN, reg_wr_q, mem_rd_q, rd_q, alu_q, wbRegWr, wbRd, wbData);
    fwd_b = fwd_sel(rt_IN, regData2_IN, reg_wr_q, mem_rd_q, rd_q, alu_q, wbRegWr, wbRd, wbData);
    op_b  = aluOp_IN[3] ? immConst_IN : fwd_b;
  end

  // 9-bit ALU; bit DATA_W is the carry for adds and the borrow for subtracts.
  always_comb begin
    a9   = {1'b0, fwd_a};
    b9   = {1'b0, op_b};
    res9 = '0;
    case (aluOp_IN[2:0])
      3'd0: res9 = a9 + b9;
      3'd1: res9 = a9 + b9 + (DATA_W+1)'(c_q);
      3'd2: res9 = a9 - b9;
      3'd3: res9 = a9 - b9 - (DATA_W+1)'(c_q);
      3'd4: res9 = {1'b0, fwd_a & op_b};
      3'd5: res9 = {1'b0, fwd_a | op_b};
      3'd6: res9 = {1'b0, fwd_a ^ op_b};
      3'd7: res9 = {1'b0, fwd_a & ~op_b};
      default: res9 = '0;
    endcase
    c_new = res9[DATA_W];
    z_new = (res9[DATA_W-1:0] == DATA_W'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      rd_q     <= '0;
      alu_q    <= '0;
      store_q  <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      reg_wr_q <= regWr_IN & ~squash;
      mem_rd_q <= memRd_IN & ~squash;
      mem_wr_q <= memWr_IN & ~squash;
      rd_q     <= rd_IN;
      alu_q    <= res9[DATA_W-1:0];
      store_q  <= fwd_b;
      if (cWr_IN && !squash) c_q <= c_new;
      if (zWr_IN && !squash) z_q <= z_new;
    end
  end

  assign regWr_OUT     = reg_wr_q;
  assign memRd_OUT     = mem_rd_q;
  assign memWr_OUT     = mem_wr_q;
  assign rd_OUT        = rd_q;
  assign aluResult_OUT = alu_q;
  assign storeData_OUT = store_q;
  assign cFlag         = c_q;
  assign zFlag         = z_q;

endmodule
